mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit in the execute stage, alongside the ALU. It takes the same rs/rt operands and writes the architectural HI/LO pair. The HI/LO outputs are muxed into the execute result path for MFHI/MFLO. While it is busy, the pipeline control stalls any MFHI/MFLO or new mul/div instruction.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only when busy=0
- op  in  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; other codes are ignored
- rs  in  WIDTH  first operand (multiplicand / dividend / move source)
- rt  in  WIDTH  second operand (multiplier / divisor)
- flush  in  1  abort the in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO have been committed
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- dz  out  1  sticky until next start: the last DIV/DIVU had rt=0

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, valid op:
  - MULT/MULTU → MUL.
  - DIV/DIVU with rt≠0 → DIV.
  - DIV/DIVU with rt=0 → commit at once: LO=all-ones, HI=rs, dz=1, done pulse; stay IDLE.
  - MTHI/MTLO → write rs to HI or LO; done pulse; stay IDLE.
- Operand capture:
  - Signed ops latch |rs| and |rt| and record the result signs.
  - Product sign = rs[31]^rt[31].
  - Quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
- MUL: radix-2 shift-add over a 2·WIDTH accumulator, one bit per cycle, WIDTH cycles.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles. Each step is done by sub-module mdu_divstep.
- Iteration count: a 6-bit counter loads WIDTH-1 and moves to FIX after reaching 0.
- FIX (one cycle):
  - Conditionally two's-complement negate the results.
  - Write HI/LO: product {HI,LO}; quotient → LO; remainder → HI.
  - Pulse done; go to IDLE.
- Arithmetic rules:
  - All internal arithmetic is unsigned on magnitudes of width WIDTH+1.
  - DIV of −2^31 by −1 gives LO=0x80000000, HI=0. There is no trap.
- Start while busy is ignored. HI/LO change only on commit, MTHI or MTLO.
- Flush:
  - In MUL/DIV/FIX: flush → IDLE next edge; no commit, no done; HI/LO keep their old values.
  - Flush with start in IDLE: flush wins and nothing happens.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, dz=0, counter=0.

## Timing
- Edge E0 samples start.
- Iterative ops:
  - busy=1 from after E0 through E33.
  - hi/lo update at E33; done=1 in the cycle after E33, with busy=0.
  - Start-to-done latency: 34 cycles.
- A new start is accepted in the same cycle that done=1.
- MTHI/MTLO and divide-by-zero: write at E0; done in the next cycle; busy never asserts.
- done is registered and lasts exactly one cycle.
- Reset asserted mid-operation returns immediately to reset values, with no done.

## Configuration
- Macro MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle WIDTH×WIDTH combinational product registered in FIX.
  - Path is IDLE → FIX → IDLE; busy for one cycle; done two cycles after start.
- Undefined: iterative multiply as described above.
- Divide is always iterative.

## Structure
- Package mdu_pkg holds:
  - op codes (MDU_MULT … MDU_MTLO);
  - state encoding;
  - latency constants MDU_ITER=WIDTH and MDU_LAT=WIDTH+2.
- Sub-module mdu_divstep is combinational: (rem, quot, divisor) in → shifted rem, quot with new bit out.
- The top level holds the FSM, counter, sign capture/fix and HI/LO registers.

## Test plan
- MULT rs=−3 (0xFFFFFFFD), rt=7 → 34 cycles later done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. With MDU_FAST_MUL_EN the same result arrives with done two cycles after start.
- DIV rs=−7, rt=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU rs=100, rt=7 → LO=14, HI=2.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0, dz=0. DIVU rs=5, rt=0 → next cycle done=1, dz=1, LO=0xFFFFFFFF, HI=5, busy stays 0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi=0x1234, lo=0x5678, two done pulses. Then start DIVU, assert flush at cycle 10 → busy=0 next cycle, no done, HI/LO unchanged.
- Start MULT, assert start again with DIV at cycle 5 → second request ignored, single done at cycle 34. Pulse rst_n low mid-DIV → hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and latency constants for the mdu block.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;
  localparam int MDU_LAT   = MDU_WIDTH + 2;

  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit, trial-subtract.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_dvsr};
  assign w_ge    = ~w_diff[WIDTH+1];

  // Remainder stays below the divisor, so WIDTH bits always hold it.
  assign o_rem   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quot  = {i_quot[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit writing HI/LO. Define MDU_FAST_MUL_EN for a
// single-cycle combinational multiply (IDLE->FIX->IDLE); divide is always iterative.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  mdu_state_e         r_state;
  logic [5:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // {rem,quot} for divide, {hi,lo} partial product for multiply
  logic [WIDTH-1:0]   r_dvsr;    // multiplicand or divisor magnitude
  logic               r_is_div;
  logic               r_neg_a;   // product / quotient sign
  logic               r_neg_r;   // remainder sign
  logic               r_busy, r_done, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_signed, w_is_mul, w_is_div, w_rs_neg, w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag, w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_prod_mag, w_prod;
  logic [WIDTH-1:0]   w_div_rem, w_div_quot, w_quot, w_rem;

  assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
  assign w_is_div = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign w_rs_neg = w_signed & rs[WIDTH-1];
  assign w_rt_neg = w_signed & rt[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs : rs;
  assign w_rt_mag = w_rt_neg ? -rt : rt;

  // Radix-2 shift-add: add multiplicand into the upper half when the LSB is set, then shift right.
  assign w_addend   = r_acc[0] ? r_dvsr : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem  (r_acc[2*WIDTH-1:WIDTH]),
    .i_quot (r_acc[WIDTH-1:0]),
    .i_dvsr (r_dvsr),
    .o_rem  (w_div_rem),
    .o_quot (w_div_quot)
  );

`ifdef MDU_FAST_MUL_EN
  assign w_prod_mag = {{WIDTH{1'b0}}, r_dvsr} * {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
`else
  assign w_prod_mag = r_acc;
`endif

  assign w_prod = r_neg_a ? -w_prod_mag : w_prod_mag;
  assign w_quot = r_neg_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dvsr   <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (w_is_mul) begin
              r_dz     <= 1'b0;
              r_is_div <= 1'b0;
              r_neg_a  <= w_rs_neg ^ w_rt_neg;
              r_dvsr   <= w_rs_mag;
              r_acc    <= {{WIDTH{1'b0}}, w_rt_mag};
              r_cnt    <= 6'(WIDTH - 1);
              r_busy   <= 1'b1;
`ifdef MDU_FAST_MUL_EN
              r_state  <= ST_FIX;
`else
              r_state  <= ST_MUL;
`endif
            end else if (w_is_div) begin
              if (rt == '0) begin
                // Divide by zero commits immediately; no trap.
                r_dz   <= 1'b1;
                r_lo   <= '1;
                r_hi   <= rs;
                r_done <= 1'b1;
              end else begin
                r_dz     <= 1'b0;
                r_is_div <= 1'b1;
                r_neg_a  <= w_rs_neg ^ w_rt_neg;
                r_neg_r  <= w_rs_neg;
                r_dvsr   <= w_rt_mag;
                r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
                r_cnt    <= 6'(WIDTH - 1);
                r_busy   <= 1'b1;
                r_state  <= ST_DIV;
              end
            end else if (op == MDU_MTHI) begin
              r_dz   <= 1'b0;
              r_hi   <= rs;
              r_done <= 1'b1;
            end else if (op == MDU_MTLO) begin
              r_dz   <= 1'b0;
              r_lo   <= rs;
              r_done <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= (r_state == ST_DIV) ? {w_div_rem, w_div_quot} : w_mul_next;
            if (r_cnt == '0) r_state <= ST_FIX;
            else             r_cnt   <= r_cnt - 6'd1;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              r_lo <= w_quot;
              r_hi <= w_rem;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign dz   = r_dz;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops against an arithmetic reference model.
module tb_mdu;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Edges after the sampling edge until done is visible.
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        flush = 1'b0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  // Reference model: architectural effect of one accepted op.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic exp_busy);
    longint      sa, sb, q, r, p;
    logic [63:0] up;
    lat = 0; exp_busy = 1'b0;
    case (o)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = p; m_dz = 1'b0; lat = MUL_LAT; exp_busy = 1'b1;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = up; m_dz = 1'b0; lat = MUL_LAT; exp_busy = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1;
        end else begin
          if (o == OP_DIV) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
          end
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; m_dz = 1'b0;
          lat = DIV_LAT; exp_busy = 1'b1;
        end
      end
      OP_MTHI: begin m_hi = a; m_dz = 1'b0; end
      OP_MTLO: begin m_lo = a; m_dz = 1'b0; end
      default: ;
    endcase
  endtask

  // Drive one request; report edges-to-done (bounded) and busy just after the sampling edge.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic b0);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    b0 = busy;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy, done, dz, hi, lo} !== 67'd0) begin
      n_errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h, want all 0", busy, done, dz, hi, lo);
    end
  endtask

  task automatic test_mult;
    int n, lat; logic b0, eb;
    model(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, eb);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, n, b0);
    n_checks++;
    if (n !== MUL_LAT || b0 !== 1'b1) begin
      n_errors++; $display("FAIL mult_timing: lat=%0d busy=%b, want %0d 1", n, b0, MUL_LAT);
    end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || busy !== 1'b0) begin
      n_errors++; $display("FAIL mult: hi=%h lo=%h busy=%b, want ffffffff ffffffeb 0", hi, lo, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++; $display("FAIL done_width: done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_multu;
    int n, lat; logic b0, eb;
    model(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, eb);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, b0);
    n_checks++;
    if (n !== MUL_LAT || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_errors++; $display("FAIL multu: lat=%0d hi=%h lo=%h, want %0d fffffffe 00000001", n, hi, lo, MUL_LAT);
    end
  endtask

  task automatic test_div;
    int n, lat; logic b0, eb;
    model(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, eb);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, b0);
    n_checks++;
    if (n !== DIV_LAT || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      n_errors++; $display("FAIL div_neg: lat=%0d hi=%h lo=%h, want 33 ffffffff fffffffd", n, hi, lo);
    end
    model(OP_DIVU, 32'd100, 32'd7, lat, eb);
    do_op(OP_DIVU, 32'd100, 32'd7, n, b0);
    n_checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
      n_errors++; $display("FAIL divu: hi=%0d lo=%0d dz=%b, want 2 14 0", hi, lo, dz);
    end
  endtask

  task automatic test_div_edges;
    int n, lat; logic b0, eb;
    model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, eb);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, b0);
    n_checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0 || dz !== 1'b0) begin
      n_errors++; $display("FAIL div_ovf: hi=%h lo=%h dz=%b, want 0 80000000 0", hi, lo, dz);
    end
    model(OP_DIVU, 32'd5, 32'd0, lat, eb);
    do_op(OP_DIVU, 32'd5, 32'd0, n, b0);
    n_checks++;
    if (n !== 0 || b0 !== 1'b0 || dz !== 1'b1 || lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      n_errors++;
      $display("FAIL div_zero: lat=%0d busy=%b dz=%b hi=%h lo=%h, want 0 0 1 5 ffffffff", n, b0, dz, hi, lo);
    end
  endtask

  task automatic test_move_flush;
    int lat, cnt; logic eb;
    model(OP_MTHI, 32'h1234, 32'd0, lat, eb);
    model(OP_MTLO, 32'h5678, 32'd0, lat, eb);
    start = 1'b1; op = OP_MTHI; rs = 32'h1234;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || hi !== 32'h1234 || busy !== 1'b0) begin
      n_errors++; $display("FAIL mthi: done=%b hi=%h busy=%b, want 1 1234 0", done, hi, busy);
    end
    op = OP_MTLO; rs = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    n_checks++;
    if (done !== 1'b1 || hi !== 32'h1234 || lo !== 32'h5678) begin
      n_errors++; $display("FAIL mtlo: done=%b hi=%h lo=%h, want 1 1234 5678", done, hi, lo);
    end
    // DIVU aborted mid-flight: no commit, no done.
    start = 1'b1; op = OP_DIVU; rs = 32'd1000; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_errors++;
      $display("FAIL flush: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h", busy, done, hi, lo, m_hi, m_lo);
    end
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 0 || hi !== m_hi || lo !== m_lo) begin
      n_errors++; $display("FAIL flush_quiet: dones=%0d hi=%h lo=%h, want 0 %h %h", cnt, hi, lo, m_hi, m_lo);
    end
    // Flush together with start in IDLE: nothing happens.
    start = 1'b1; flush = 1'b1; op = OP_MTHI; rs = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi) begin
      n_errors++; $display("FAIL flush_start: done=%b busy=%b hi=%h, want 0 0 %h", done, busy, hi, m_hi);
    end
  endtask

  task automatic test_busy_ignore;
    int n, lat, cnt; logic eb;
    logic [2:0] o1;
`ifdef MDU_FAST_MUL_EN
    o1 = OP_DIV;
`else
    o1 = OP_MULT;
`endif
    model(o1, 32'hFFFF_0123, 32'h0000_4567, lat, eb);
    start = 1'b1; op = o1; rs = 32'hFFFF_0123; rt = 32'h0000_4567;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      if (n == 4) begin start = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd3; end
      else begin start = 1'b0; op = 3'd0; end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; op = 3'd0;
    n_checks++;
    if (n !== 33 || hi !== m_hi || lo !== m_lo) begin
      n_errors++; $display("FAIL busy_ignore: lat=%0d hi=%h lo=%h, want 33 %h %h", n, hi, lo, m_hi, m_lo);
    end
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL busy_ignore_single: extra dones=%0d busy=%b, want 0 0", cnt, busy);
    end
  endtask

  // Random ops issued back-to-back: each new start is driven in the cycle done is high.
  task automatic test_random;
    int n, lat; logic b0, eb;
    logic [2:0] o; logic [31:0] a, b;
    logic [31:0] ph, pl;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      if (o == 3'd0 || o == 3'd7) begin
        ph = m_hi; pl = m_lo;
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== ph || lo !== pl) begin
          n_errors++; $display("FAIL rand_badop[%0d]: op=%0d done=%b busy=%b hi=%h lo=%h", i, o, done, busy, hi, lo);
        end
      end else begin
        model(o, a, b, lat, eb);
        do_op(o, a, b, n, b0);
        n_checks++;
        if (n !== lat || b0 !== eb || hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
          n_errors++;
          $display("FAIL rand[%0d]: op=%0d rs=%h rt=%h lat=%0d/%0d busy0=%b/%b hi=%h/%h lo=%h/%h",
                   i, o, a, b, n, lat, b0, eb, hi, m_hi, lo, m_lo);
        end
        if (o == OP_DIV || o == OP_DIVU) begin
          n_checks++;
          if (dz !== m_dz) begin
            n_errors++; $display("FAIL rand_dz[%0d]: dz=%b, want %b", i, dz, m_dz);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    start = 1'b1; op = OP_DIV; rs = 32'h1234_5678; rt = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0) begin
      n_errors++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b dz=%b, want all 0", hi, lo, busy, done, dz);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) cnt++; end
    n_checks++;
    if (cnt !== 0) begin
      n_errors++; $display("FAIL reset_mid_quiet: active cycles=%0d, want 0", cnt);
    end
  endtask

  initial begin
    #12;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_mult;
    test_multu;
    test_div;
    test_div_edges;
    test_move_flush;
    test_busy_ignore;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
